// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

    // Upper bound on operand width; stage bundles are sized to this.
    localparam int unsigned ADDER_MAX_WIDTH = 64;

    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit config_ok(input int unsigned width, input int unsigned stages);
        return (stages != 0) && (width != 0) && (width % stages == 0) && (width <= ADDER_MAX_WIDTH);
    endfunction

    // Per-stage bundle. remaining_* hold the not-yet-added operand bits,
    // right-aligned so the next chunk always sits in the low CHUNK bits.
    typedef struct packed {
        logic                       valid;
        logic                       carry;
        logic [ADDER_MAX_WIDTH-1:0] partial_sum;
        logic [ADDER_MAX_WIDTH-1:0] remaining_a;
        logic [ADDER_MAX_WIDTH-1:0] remaining_b;
    } stage_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple of 1-bit full-adder cells; exposes the carry into the
// MSB so the final stage can derive signed overflow.
module adder_chunk #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] c;

    // NOTE: blocking assignments in combinational logic so each cell sees the
    // carry produced by the cell below it in the same evaluation.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit ripple segment per stage.
// Define ADDER_ZERO_FLAG_EN to add a registered zero-result output.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_bad_config
        $error("pipelined_adder: STAGES must divide WIDTH and WIDTH must not exceed ADDER_MAX_WIDTH");
    end

    stage_t stage_q   [STAGES];
    logic   msb_carry [STAGES];
    stage_t in_stage;
    logic   stall;
    logic   advance;
    logic   ovf_q;

    // The whole pipeline freezes while the output beat waits downstream.
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    // Subtraction folds into the add as A + ~B + 1 (cin toggles the +1).
    always_comb begin
        in_stage             = '0;
        in_stage.valid       = in_valid;
        in_stage.carry       = cin ^ sub;
        in_stage.remaining_a = ADDER_MAX_WIDTH'(a);
        in_stage.remaining_b = ADDER_MAX_WIDTH'(sub ? ~b : b);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           nxt;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_cout;

        if (k == 0) begin : g_first
            assign src = in_stage;
        end else begin : g_next
            assign src = stage_q[k-1];
        end

        adder_chunk #(
            .WIDTH (CHUNK)
        ) u_chunk (
            .a     (src.remaining_a[CHUNK-1:0]),
            .b     (src.remaining_b[CHUNK-1:0]),
            .cin   (src.carry),
            .sum   (chunk_sum),
            .cout  (chunk_cout),
            .c_msb (msb_carry[k])
        );

        // Finished bits accumulate in place (de-skew); operands shift down one chunk.
        always_comb begin
            nxt             = src;
            nxt.carry       = chunk_cout;
            nxt.partial_sum = src.partial_sum | (ADDER_MAX_WIDTH'(chunk_sum) << (k * CHUNK));
            nxt.remaining_a = src.remaining_a >> CHUNK;
            nxt.remaining_b = src.remaining_b >> CHUNK;
        end

        // NOTE: datapath fields are reset along with valid because sum/cout
        // are read straight from the last stage and must read 0 in reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q[k] <= '0;
            end else if (advance) begin
                stage_q[k] <= nxt;
            end
        end

        if (k == STAGES - 1) begin : g_last
            // NOTE: non-blocking assignments for every register so all stages
            // sample the pre-edge values and shift together.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= msb_carry[k] ^ chunk_cout;
                end
            end

`ifdef ADDER_ZERO_FLAG_EN
            logic zero_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    zero_q <= 1'b0;
                end else if (advance) begin
                    zero_q <= (nxt.partial_sum[WIDTH-1:0] == '0);
                end
            end

            assign zero = zero_q;
`endif
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].partial_sum[WIDTH-1:0];
    assign cout      = stage_q[STAGES-1].carry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4): latency, streaming,
// stall, mid-flight reset and a model-checked random stream.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef ADDER_ZERO_FLAG_EN
    logic             zero;
`endif

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef ADDER_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [12];

    logic [31:0] beat_a   [256];
    logic [31:0] beat_b   [256];
    logic        beat_cin [256];
    logic        beat_sub [256];
    logic [63:0] beat_exp [256];

    function automatic logic [63:0] pack(input logic [31:0] s, input logic co, input logic ov);
`ifdef ADDER_ZERO_FLAG_EN
        return 64'({(s == 32'h0), co, ov, s});
`else
        return 64'({co, ov, s});
`endif
    endfunction

    function automatic logic [63:0] obs();
`ifdef ADDER_ZERO_FLAG_EN
        return 64'({zero, cout, ovf, sum});
`else
        return 64'({cout, ovf, sum});
`endif
    endfunction

    // Reference: plain 33-bit add; overflow from operand/result signs.
    function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        logic [31:0] be;
        logic [32:0] t;
        logic        ov;
        be = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, be} + 33'(mcin ^ msub);
        ov = (ma[31] == be[31]) && (t[31] != ma[31]);
        return pack(t[31:0], t[32], ov);
    endfunction

    task automatic load_vec(input int dst, input int v);
        beat_a[dst]   = vecs[v].a;
        beat_b[dst]   = vecs[v].b;
        beat_cin[dst] = vecs[v].cin;
        beat_sub[dst] = vecs[v].sub;
        beat_exp[dst] = pack(vecs[v].s, vecs[v].co, vecs[v].ov);
    endtask

    // One isolated beat: measure latency in clock edges, then check result.
    task automatic run_single(input int v);
        int lat;
        @(negedge clk);
        a = vecs[v].a; b = vecs[v].b; cin = vecs[v].cin; sub = vecs[v].sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("lat_v%0d", v), 64'(lat), 64'(STAGES));
        check($sformatf("res_v%0d", v), obs(), pack(vecs[v].s, vecs[v].co, vecs[v].ov));
    endtask

    // Stream n beats back to back; out_ready drops for stall_len cycles at stall_at.
    task automatic run_stream(input int n, input int stall_at, input int stall_len);
        int sent      = 0;
        int got       = 0;
        int cyc       = 0;
        int first_cyc = -1;
        int last_cyc  = -1;
        bit acc;
        while ((sent < n || got < n) && cyc < n + stall_len + 40) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                a = beat_a[sent]; b = beat_b[sent]; cin = beat_cin[sent]; sub = beat_sub[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (!out_ready) begin
                    check("stall_in_ready", 64'(in_ready), 64'(0));
                    check("stall_hold", obs(), beat_exp[got]);
                end else if (got < n) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    check($sformatf("stream_%0d", got), obs(), beat_exp[got]);
                    got++;
                end else begin
                    check("stream_extra", 64'(1), 64'(0));
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got), 64'(n));
        check("stream_first", 64'(first_cyc), 64'(STAGES));
        check("stream_span", 64'(last_cyc), 64'(STAGES + n - 1 + stall_len));
    endtask

    initial begin
        int stale;

        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
        vecs[7]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", obs(), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_single(i);

        for (int i = 0; i < 8; i++) load_vec(i, i);
        run_stream(8, 1000, 0);

        for (int i = 0; i < 8; i++) load_vec(i, i + 4);
        run_stream(8, 6, 3);

        for (int i = 0; i < 200; i++) begin
            beat_a[i]   = $urandom;
            beat_b[i]   = (i % 7 == 0) ? ~beat_a[i] : $urandom;
            beat_cin[i] = 1'($urandom_range(0, 1));
            beat_sub[i] = 1'($urandom_range(0, 1));
            beat_exp[i] = model(beat_a[i], beat_b[i], beat_cin[i], beat_sub[i]);
        end
        run_stream(200, 60, 4);

        // Reset with three beats in flight and the head beat stalled at the output.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_ready", 64'(in_ready), 64'(1));
        check("mid_rst_outputs", obs(), 64'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mid_no_stale", 64'(stale), 64'(0));
        run_single(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined N-bit adder/subtractor built as a chain of CHUNK-bit ripple segments, one segment per pipeline stage. It is the multi-bit successor to the 1-bit full-adder cell. The carry is registered between stages and the operands are skewed, so one operation can be accepted per cycle. It sits in the execute path, where a full-width ripple carry would not close timing. Valid/ready handshake on both sides, with full-pipeline stall on backpressure.

Parameters:
WIDTH, 32, operand and result width in bits.
STAGES, 4, number of pipeline stages. Must divide WIDTH; CHUNK = WIDTH/STAGES. STAGES=1 is legal and gives a single registered stage.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  adder can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
sub  input  1  1 = A - B (B inverted, carry-in = cin ^ 1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB; for subtraction, 1 = no borrow
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear, out_valid=0, sum=0, cout=0, ovf=0. All in-flight beats are discarded. in_ready reads 1 while reset is low and after it deasserts.
- Accept: a beat is accepted on a rising edge when in_valid && in_ready. Effective B = sub ? ~b : b. Effective carry-in = cin ^ sub.
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of A and effective B, plus the registered carry from stage k-1 (stage 0 uses the effective carry-in).
  - Registers its partial sum and carry-out.
  - Carries the not-yet-processed upper operand bits forward (skew registers).
  - Completed lower sum bits are delayed (de-skewed) so that all result bits leave together.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1, with no stall.
- Throughput: one beat per cycle.
- Stall: stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every stage register (data, carry, valid) holds its value.
  - out_valid and sum/cout/ovf stay stable until the transfer completes.
- Bubbles are not compressed; a valid bit travels with each stage's data.
- Simultaneous events:
  - Output transfer and input accept in the same cycle are both legal; the pipeline advances one stage.
  - in_valid while in_ready=0 is ignored; upstream must hold its beat.
- Output flags:
  - ovf is computed in the final stage from the MSB carry-in and carry-out.
  - cout is the carry-out of the final stage.
  - sum wraps modulo 2^WIDTH.
- Outputs are registered; no combinational path from a/b to sum.

Optional Feature:
ADDER_ZERO_FLAG_EN
- Defined: adds output port zero (1 bit), asserted when sum == 0. Registered alongside sum with the same timing and stall behaviour; reset value 0.
- Undefined: the port is absent and no zero-detect logic is built.

Decomposition:
- Package adder_pkg holds:
  - localparam function CHUNK = WIDTH/STAGES
  - the elaboration-time check that STAGES divides WIDTH
  - a typedef for the per-stage bundle {valid, carry, partial_sum, remaining_a, remaining_b}
- One sub-module, adder_chunk: combinational CHUNK-bit ripple of 1-bit full-adder cells. It exposes carry-in, carry-out and the carry into its MSB, which the top level needs for ovf on the last stage.
- The top level generate-loops STAGES instances of adder_chunk plus the stage registers.

Test Plan:
- Basic add (WIDTH=32, STAGES=4): a=0x0000_0005, b=0x0000_0003, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x0000_0008, cout=0, ovf=0.
- Cross-stage carry: a=0xFFFF_FFFF, b=0x0000_0001 -> sum=0x0000_0000, cout=1, ovf=0; zero=1 when ADDER_ZERO_FLAG_EN is defined.
- Signed overflow and subtract:
  - a=0x7FFF_FFFF, b=1, add -> sum=0x8000_0000, ovf=1.
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0 (borrow).
- Back-to-back plus stall:
  - Stream 8 beats with out_ready=1 -> one result per cycle, in order.
  - Drop out_ready for 3 cycles mid-stream -> in_ready=0, held result unchanged, no beats lost or duplicated.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; after release, no stale result ever appears.
- Randomised sweep (exhaustive at WIDTH=4, STAGES=2; 10k random beats at 32/4) -> sum, cout and ovf match the reference model {cout,sum} = a + (sub?~b:b) + (cin^sub).
